// File: rtl/gpu_cmd_tx_if.sv
// Request channel into the GPU command transmitter: one (command, parameter) pair per handshake.
// Latency: none; this interface is wires only.
// Backpressure: the producer holds in_valid/in_cmd/in_param until it sees in_ready high.
interface gpu_cmd_tx_if;
    logic        in_valid;
    logic [15:0] in_cmd;
    logic [15:0] in_param;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_cmd,
        output in_param,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_cmd,
        input  in_param,
        output in_ready
    );
endinterface

// File: rtl/gpu_cmd_tx.sv
// Filters and buffers GPU text-mode commands, then serialises them as cmd/param/exe frames on cpuline.
// Latency: a request is visible the cycle after enqueue; its command appears 1-3 cycles later, aligned to GPU phase A.
// Backpressure: in_ready drops while the registered FIFO level is DEPTH or clr is low; a same-cycle pop frees no slot.
module gpu_cmd_tx #(
    parameter int DEPTH = 8,
    parameter int COLS  = 40,
    parameter int ROWS  = 25
) (
    input  logic                     clk,
    input  logic                     clr,
    gpu_cmd_tx_if.slave              req,
    output logic [15:0]              cpuline,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // NOP0/NOP1 are the idle phase-A/phase-B words; CMD, PAR, EXE form one frame.
    typedef enum logic [2:0] {
        NOP0 = 3'd0,
        NOP1 = 3'd1,
        CMD  = 3'd2,
        PAR  = 3'd3,
        EXE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     cpuline_nxt;
    logic [15:0]     cur_param;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;

    assign req.in_ready = clr && (level < LW'(DEPTH));
    assign accept       = req.in_valid && req.in_ready;
    assign push         = accept && legal;
    assign busy         = (level != '0) || (state == CMD) || (state == PAR) || (state == EXE);

    // Reject opcodes the GPU does not know and cursor moves outside the text grid.
    always_comb begin
        legal = 1'b0;
        case (req.in_cmd)
            16'hC1, 16'hC2, 16'hC5, 16'hC6: legal = 1'b1;
            16'hC3:                         legal = (req.in_param <= 16'(ROWS - 1));
            16'hC4:                         legal = (req.in_param <= 16'(COLS - 1));
            default:                        legal = 1'b0;
        endcase
    end

    // Next line word and frame sequencing; a pop is only taken at the end of a phase-B slot.
    always_comb begin
        state_nxt   = state;
        cpuline_nxt = 16'h0;
        pop         = 1'b0;
        case (state)
            NOP0: state_nxt = NOP1;
            NOP1, EXE: begin
                if (level != '0) begin
                    pop         = 1'b1;
                    state_nxt   = CMD;
                    cpuline_nxt = mem[rd_ptr][31:16];
                end else begin
                    state_nxt   = NOP0;
                end
            end
            CMD: begin
                state_nxt   = PAR;
                cpuline_nxt = cur_param;
            end
            PAR:     state_nxt = EXE;
            default: state_nxt = NOP0;
        endcase
    end

    // State and line register; reset always restarts on a phase-A idle word.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= NOP0;
            cpuline <= 16'h0;
        end else begin
            state   <= state_nxt;
            cpuline <= cpuline_nxt;
        end
    end

    // FIFO pointers, occupancy and the one-cycle drop pulse.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
            err   <= accept && !legal;
        end
    end

    // Entry storage and the parameter latch for the frame in flight; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req.in_cmd, req.in_param};
        end
        if (pop) begin
            cur_param <= mem[rd_ptr][15:0];
        end
    end

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Bench for gpu_cmd_tx: directed test-plan sequences followed by random traffic and random resets.
// Latency: expectations come from a word-queue model of the command line, compared every cycle.
// Backpressure: requests are offered one per cycle and are accepted only where the model predicts in_ready.
module tb_gpu_cmd_tx;

    localparam int DEPTH = 8;
    localparam int COLS  = 40;
    localparam int ROWS  = 25;

    typedef struct packed {
        logic [15:0] w;
        logic        in_frame;
    } word_t;

    logic                   clk;
    logic                   clr;
    logic [15:0]            cpuline;
    logic                   err;
    logic [$clog2(DEPTH):0] level;
    logic                   busy;

    gpu_cmd_tx_if rq ();

    gpu_cmd_tx #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (rq),
        .cpuline (cpuline),
        .err     (err),
        .level   (level),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: requests waiting in the FIFO, and the words the line is committed to emit.
    logic [31:0] fq[$];
    word_t       lq[$];
    logic        err_e;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic word_t mk(input logic [15:0] w, input logic f);
        word_t r;
        r.w        = w;
        r.in_frame = f;
        return r;
    endfunction

    function automatic logic legal_m(input logic [15:0] c, input logic [15:0] p);
        if (c inside {16'hC1, 16'hC2, 16'hC5, 16'hC6}) return 1'b1;
        if (c == 16'hC3) return int'(p) < ROWS;
        if (c == 16'hC4) return int'(p) < COLS;
        return 1'b0;
    endfunction

    task automatic model_reset();
        fq.delete();
        lq.delete();
        lq.push_back(mk(16'h0, 1'b0));
        lq.push_back(mk(16'h0, 1'b0));
        err_e = 1'b0;
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model across the rising edge.
    task automatic step(input logic v, input logic [15:0] c, input logic [15:0] p, input logic cl);
        logic        exp_rdy;
        logic        acc;
        logic [31:0] f;
        word_t       cur;
        clr         = cl;
        rq.in_valid = v;
        rq.in_cmd   = c;
        rq.in_param = p;
        @(negedge clk);
        cur     = lq[0];
        exp_rdy = cl && (fq.size() < DEPTH);
        chk_val("cpuline", 32'(cpuline), 32'(cur.w));
        chk_val("err", 32'(err), 32'(err_e));
        chk_val("level", 32'(level), 32'(fq.size()));
        chk_val("in_ready", 32'(rq.in_ready), 32'(exp_rdy));
        chk_val("busy", 32'(busy), 32'((fq.size() != 0) || cur.in_frame));
        acc = v && exp_rdy;
        @(posedge clk);
        if (!cl) begin
            model_reset();
        end else begin
            if (lq.size() == 1) begin
                if (fq.size() != 0) begin
                    f = fq.pop_front();
                    lq.push_back(mk(f[31:16], 1'b1));
                    lq.push_back(mk(f[15:0], 1'b1));
                    lq.push_back(mk(16'h0, 1'b1));
                end else begin
                    lq.push_back(mk(16'h0, 1'b0));
                    lq.push_back(mk(16'h0, 1'b0));
                end
            end
            void'(lq.pop_front());
            err_e = acc && !legal_m(c, p);
            if (acc && legal_m(c, p)) fq.push_back({c, p});
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    logic [15:0] cmd_tab [9];
    logic [15:0] rc;
    logic [15:0] rp;

    initial begin
        cmd_tab[0] = 16'hC0; cmd_tab[1] = 16'hC1; cmd_tab[2] = 16'hC2;
        cmd_tab[3] = 16'hC3; cmd_tab[4] = 16'hC4; cmd_tab[5] = 16'hC5;
        cmd_tab[6] = 16'hC6; cmd_tab[7] = 16'h0;  cmd_tab[8] = 16'hC7;

        clr         = 1'b0;
        rq.in_valid = 1'b0;
        rq.in_cmd   = 16'h0;
        rq.in_param = 16'h0;
        @(posedge clk);
        model_reset();
        #1;

        // Reset held, then a single push in the phase-A idle cycle.
        step(1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b1, 16'hC1, 16'h0041, 1'b1);
        idle(8);

        // Back-to-back legal requests.
        step(1'b1, 16'hC1, 16'h0041, 1'b1);
        step(1'b1, 16'hC1, 16'h0042, 1'b1);
        step(1'b1, 16'hC6, 16'h0000, 1'b1);
        idle(12);

        // Illegal opcodes and out-of-range cursor moves.
        step(1'b1, 16'hC0, 16'h0000, 1'b1);
        step(1'b1, 16'h0000, 16'h0005, 1'b1);
        step(1'b1, 16'hC3, 16'(ROWS), 1'b1);
        step(1'b1, 16'hC4, 16'(COLS), 1'b1);
        idle(4);

        // Cursor boundaries.
        step(1'b1, 16'hC3, 16'(ROWS - 1), 1'b1);
        step(1'b1, 16'hC4, 16'(COLS - 1), 1'b1);
        idle(10);

        // Saturate the FIFO so in_ready drops at level DEPTH.
        for (int i = 0; i < 16; i++) step(1'b1, 16'hC1, 16'(i), 1'b1);
        idle(40);

        // Reset in the middle of a frame with a backlog, then restart.
        for (int i = 0; i < 5; i++) step(1'b1, 16'hC2, 16'(16'h100 + i), 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b1, 16'hC5, 16'h0007, 1'b1);
        idle(8);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rc = cmd_tab[$urandom_range(0, 8)];
            rp = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 45));
            step($urandom_range(0, 99) < 55, rc, rp, $urandom_range(0, 199) != 0);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_tx.md
Name: gpu_cmd_tx

Overview:
CPU-side transmitter for the GPU text-mode command link. It accepts (command, parameter) requests on a valid/ready interface and buffers them in a small FIFO. It then serialises each request onto the shared 16-bit command line as a command word followed by a parameter word, phase-aligned to the GPU's two-word fetch cycle and its one-cycle execute slot. Illegal commands and out-of-range cursor parameters are filtered out, because the GPU would otherwise lock up or mis-address its text RAM.

Parameters:
DEPTH, 8, request FIFO depth in entries; power of two, 2 or more.
COLS, 40, text columns; C4 parameter limit is COLS-1.
ROWS, 25, text rows; C3 parameter limit is ROWS-1.

Ports:
clk  in  1  system clock, shared with the GPU.
clr  in  1  reset; synchronous, active-low. The GPU must be in reset on the same cycles.
in_valid  in  1  request valid.
in_cmd  in  16  command opcode.
in_param  in  16  command parameter.
in_ready  out  1  request accepted on a cycle where in_valid && in_ready.
cpuline  out  16  registered command line to the GPU.
err  out  1  one-cycle pulse when an accepted request is dropped as illegal.
level  out  $clog2(DEPTH)+1  FIFO occupancy.
busy  out  1  high when the FIFO is non-empty or state is CMD, PAR or EXE.

Behaviour:
- Reset (clr low at a rising edge), all values held while clr is low:
  - state=NOP0, cpuline=0, FIFO empty, level=0, err=0, busy=0, in_ready=0.
- in_ready = clr && (level < DEPTH). Full is decided on the registered level, so a pop in the same cycle does not free a slot.
- Legal requests, enqueued as {in_cmd, in_param}:
  - in_cmd is one of 16'hC1, C2, C5 or C6 (any param).
  - in_cmd==16'hC3 with in_param <= ROWS-1.
  - in_cmd==16'hC4 with in_param <= COLS-1.
- Any other accepted request, including C0 (which hangs the GPU) and 0, is consumed but not enqueued. err=1 on the next cycle for exactly one cycle.
- State names the word on cpuline this cycle. The GPU fetches the command word in phase A, the parameter in phase B, then executes in one extra cycle.
  - NOP0: cpuline=0, GPU phase A. Next state is NOP1.
  - NOP1: cpuline=0, GPU phase B. If the FIFO is non-empty, pop the head, next state CMD with cpuline=cmd. Otherwise next state NOP0.
  - CMD: cpuline=head cmd. Next state PAR with cpuline=param.
  - PAR: cpuline=param. Next state EXE with cpuline=0.
  - EXE: GPU executes and ignores the line; cpuline=0. Transitions are identical to NOP1: pop to CMD if non-empty, else NOP0.
- Command words appear only in GPU phase A. Idle zero words are always emitted in A/B pairs, so the GPU never desynchronises.
- Throughput: back-to-back frames are CMD, PAR, EXE, CMD, PAR, EXE, and so on, one request per 3 cycles. Idle-to-first-command latency depends on phase:
  - 1 cycle if the request is in the FIFO while in NOP1.
  - Up to 3 cycles after enqueue otherwise.
- Earliest command after reset release: cycle 2 (NOP0, NOP1, CMD).
- Push and pop in the same cycle: level unchanged; FIFO order preserved.
- A request pushed in a cycle is visible for pop from the next cycle onward (no fall-through).
- Reset mid-frame: the frame is abandoned, the FIFO is cleared, state returns to NOP0. The GPU is reset alongside, so no partial frame is resumed.
- Pointers wrap modulo DEPTH. level = pushes - pops, never exceeds DEPTH.

Test Plan:
- Reset then single push {C1, 0x0041} in the idle cycle before NOP1 -> cpuline reads 0, 0, C1, 0x0041, 0, 0… with C1 first seen in the CMD slot. err=0 and level returns to 0.
- Push C1/0x41, C1/0x42, C6/0 back-to-back -> cpuline shows C1, 41, 0, C1, 42, 0, C6, 0, 0, then NOP pairs. The GPU model's pointer ends at 40, tmpx=0, tmpy=1.
- Push C0/0, 16'h0/5, C3/25, C4/40 -> each produces a one-cycle err pulse, level stays 0, cpuline remains 0.
- Legal boundaries C3/24 and C4/39 -> accepted without err. The GPU model reports pointer = 24*40+39 = 999.
- Fill with 8 legal requests while idle-blocked, then offer a 9th -> in_ready=0 at level=8. After the first pop in_ready returns to 1; all 9 are emitted in order.
- Assert clr low during a PAR cycle with level=3, release after 2 cycles -> cpuline=0, level=0, state NOP0. The next push is emitted from cycle 2 with correct phase.
